conv_seq_ctrl: RTL
==================

Name: conv_seq_ctrl

Overview:
Sequencer for one convolution multiply PE (16-bit operands a/b, registered 32-bit product, advance-enable input). Walks a 2-D valid-mode convolution of an IMG_H x IMG_W image with a K x K kernel. Fetches operand pairs from two synchronous-read memories and drives them into the PE. Accumulates the PE products per output pixel and streams the results out under a valid/ready handshake.

Parameters:
DATA_W, 16, operand width (image pixel, kernel coefficient)
PROD_W, 32, PE product width
K, 3, kernel side length (K >= 1)
IMG_W, 8, image width in pixels (>= K)
IMG_H, 8, image height in pixels (>= K)
ADDR_W, 8, memory address width; must cover IMG_W*IMG_H-1 and K*K-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  launch job; sampled only in IDLE
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last result is accepted
img_rd  out  1  image memory read strobe
img_addr  out  ADDR_W  image address, row-major
img_data  in  DATA_W  image read data, valid the cycle after img_rd
ker_rd  out  1  kernel memory read strobe
ker_addr  out  ADDR_W  kernel address, ki*K+kj
ker_data  in  DATA_W  kernel read data, valid the cycle after ker_rd
pe_a  out  DATA_W  PE operand a (= img_data pass-through)
pe_b  out  DATA_W  PE operand b (= ker_data pass-through)
pe_en  out  1  PE advance enable; high exactly when pe_a/pe_b are valid
pe_prod  in  PROD_W  PE registered product, valid the cycle after pe_en
res_valid  out  1  result valid
res_ready  in  1  result accepted when res_valid && res_ready
res_data  out  ACC_W  accumulated pixel, signed; ACC_W = PROD_W + clog2(K*K)
res_idx  out  ADDR_W  output pixel index, row*(IMG_W-K+1)+col

Behaviour:
- Reset: state IDLE. All outputs 0, including busy, done, rd strobes, addresses, pe_en, res_valid, res_data, res_idx. Internal counters and accumulator 0.
- FSM: IDLE -> FETCH -> DRAIN -> OUTPUT -> (FETCH | DONE) -> IDLE.
- IDLE: on start, clear row, col, ki, kj and acc; go to FETCH.
- FETCH: exactly K*K cycles. Each cycle assert img_rd and ker_rd with img_addr=(row+ki)*IMG_W+(col+kj) and ker_addr=ki*K+kj. kj is inner, ki is outer.
- Pipeline:
  - strobe at cycle t -> data at t+1; pe_en at t+1 (registered copy of rd).
  - pe_prod at t+2; acc += sign-extended pe_prod on a second-stage valid flag.
- DRAIN: 2 cycles after the last issue so the final product is accumulated; then OUTPUT.
- OUTPUT: res_valid=1; res_data=acc; res_idx=current pixel. res_data and res_idx hold stable while !res_ready.
- On handshake: clear acc and advance col. On col wrap (col == IMG_W-K), reset col and advance row. After the last pixel (row == IMG_H-K, col == IMG_W-K) go to DONE, otherwise go to FETCH in the next cycle.
- DONE: done=1 for one cycle, busy drops in the same cycle; return to IDLE.
- No operand fetch while in OUTPUT: backpressure stalls the whole pipeline. No product is lost or duplicated.
- start while busy: ignored.
- reset mid-job: immediate return to IDLE, all outputs to reset values, partial accumulation discarded.
- pe_en is never high outside the cycle after a strobe, so the PE holds its operands while idle.
- Arithmetic: signed two's complement throughout; no saturation.
- Job length: (IMG_H-K+1)*(IMG_W-K+1) results, each taking K*K+3 cycles plus stall cycles.

Optional Feature:
CONV_RELU_EN:
- Defined: res_data = 0 whenever acc is negative; res_idx and timing unchanged.
- Undefined: raw signed acc is output.
- Applied combinationally at the result register input only.

Decomposition:
- Shared package conv_pkg holds:
  - FSM state enum (IDLE, FETCH, DRAIN, OUTPUT, DONE)
  - DATA_W/PROD_W defaults
  - clog2-based ACC_W function
  - DRAIN_CYCLES=2 constant, shared with the PE latency
- One sub-module, conv_addr_gen: the row/col/ki/kj counters and address arithmetic. It has step, pixel_next and clear inputs and last_tap/last_pixel flags. The FSM and accumulator stay in the top.

Test Plan:
- K=3, 4x4 image all 1, kernel all 1, res_ready=1, PE model a*b with 1-cycle latency -> 4 results of 9 with res_idx 0..3, done pulse once, busy low afterwards.
- Same setup, image pixel = index 0..15, kernel all 1 -> results 45, 54, 81, 90.
- Image all -2, kernel all 3, CONV_RELU_EN off -> every result -54; with the macro defined -> every result 0.
- res_ready low for 5 cycles on result 1 -> res_data/res_idx stable, no strobes or pe_en during the stall; final sums unchanged.
- Reset asserted mid-FETCH of pixel 2 -> next cycle all outputs 0 and state IDLE; new start gives a full correct job from idx 0.
- start pulsed during busy -> ignored, result count unchanged; pe_en count equals 9 x number of results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM state codes, width defaults
// and the accumulator width helper.
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PROD_W_DEF = 32;

    // Registered PE latency plus the accumulate stage after the last operand issue.
    localparam int DRAIN_CYCLES = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_OUTPUT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic int acc_width(input int prod_w, input int taps);
        return prod_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Control, memory, PE and result-stream signals of the convolution sequencer.
// master is the sequencer side, slave is the surrounding memories/PE/consumer.
interface conv_seq_ctrl_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = acc_width(PROD_W_DEF, 9),
    parameter int ADDR_W = 8
);

    logic              start;
    logic              busy;
    logic              done;
    logic              img_rd;
    logic [ADDR_W-1:0] img_addr;
    logic [DATA_W-1:0] img_data;
    logic              ker_rd;
    logic [ADDR_W-1:0] ker_addr;
    logic [DATA_W-1:0] ker_data;
    logic [DATA_W-1:0] pe_a;
    logic [DATA_W-1:0] pe_b;
    logic              pe_en;
    logic [PROD_W-1:0] pe_prod;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [ADDR_W-1:0] res_idx;

    modport master (
        input  start, img_data, ker_data, pe_prod, res_ready,
        output busy, done, img_rd, img_addr, ker_rd, ker_addr,
               pe_a, pe_b, pe_en, res_valid, res_data, res_idx
    );

    modport slave (
        output start, img_data, ker_data, pe_prod, res_ready,
        input  busy, done, img_rd, img_addr, ker_rd, ker_addr,
               pe_a, pe_b, pe_en, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/conv_addr_gen.sv
// Output-pixel (row/col) and kernel-tap (ki/kj) counters with the image, kernel
// and result-index address arithmetic for a valid-mode convolution walk.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              pixel_next_i,
    output logic [ADDR_W-1:0] img_addr_o,
    output logic [ADDR_W-1:0] ker_addr_o,
    output logic [ADDR_W-1:0] pix_idx_o,
    output logic              last_tap_o,
    output logic              last_pixel_o
);

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] IMG_WV   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] KV       = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] OUT_WV   = ADDR_W'(IMG_W - K + 1);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] ki_q, ki_d;
    logic [ADDR_W-1:0] kj_q, kj_d;

    // kj is the inner tap index; both tap indices wrap to 0 after the last tap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        ki_d  = ki_q;
        kj_d  = kj_q;
        if (step_i) begin
            if (kj_q == K_LAST) begin
                kj_d = '0;
                ki_d = (ki_q == K_LAST) ? '0 : ki_q + ONE;
            end else begin
                kj_d = kj_q + ONE;
            end
        end
        if (pixel_next_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            row_q <= '0;
            col_q <= '0;
            ki_q  <= '0;
            kj_q  <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            ki_q  <= ki_d;
            kj_q  <= kj_d;
        end
    end

    assign img_addr_o   = (row_q + ki_q) * IMG_WV + (col_q + kj_q);
    assign ker_addr_o   = ki_q * KV + kj_q;
    assign pix_idx_o    = row_q * OUT_WV + col_q;
    assign last_tap_o   = (ki_q == K_LAST) && (kj_q == K_LAST);
    assign last_pixel_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer top: FSM, PE operand pipeline, accumulator and result stream.
// Build option CONV_RELU_EN clamps negative results to zero at the result register input.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    conv_seq_ctrl_if.master bus
);

    localparam int ACC_W = acc_width(PROD_W, K * K);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        drain_q, drain_d;
    logic              pe_en_q;
    logic              prod_vld_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d, res_in;
    logic [ADDR_W-1:0] res_idx_q, res_idx_d;

    logic              fetch, handshake, load_res;
    logic              clear, step, pixel_next;
    logic              last_tap, last_pixel;
    logic [ADDR_W-1:0] img_addr, ker_addr, pix_idx;
    logic [DATA_W-1:0] pe_a_w, pe_b_w;

    conv_addr_gen #(
        .K      (K),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear),
        .step_i       (step),
        .pixel_next_i (pixel_next),
        .img_addr_o   (img_addr),
        .ker_addr_o   (ker_addr),
        .pix_idx_o    (pix_idx),
        .last_tap_o   (last_tap),
        .last_pixel_o (last_pixel)
    );

    assign fetch     = (state_q == ST_FETCH);
    assign handshake = (state_q == ST_OUTPUT) && bus.res_ready;
    assign load_res  = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        clear      = 1'b0;
        step       = 1'b0;
        pixel_next = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clear   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                step = 1'b1;
                if (last_tap) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.res_ready) begin
                    pixel_next = 1'b1;
                    state_d    = last_pixel ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The result register samples acc_d so the final product lands in the same edge.
    always_comb begin
        acc_d = acc_q;
        if (prod_vld_q) acc_d = acc_q + ACC_W'($signed(bus.pe_prod));
        if (clear || handshake) acc_d = '0;
`ifdef CONV_RELU_EN
        res_in = acc_d[ACC_W-1] ? '0 : acc_d;
`else
        res_in = acc_d;
`endif
        res_data_d = load_res ? res_in : res_data_q;
        res_idx_d  = load_res ? pix_idx : res_idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            pe_en_q    <= 1'b0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            res_data_q <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            pe_en_q    <= fetch;
            prod_vld_q <= pe_en_q;
            acc_q      <= acc_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
        end
    end

    assign pe_a_w = bus.img_data;
    assign pe_b_w = bus.ker_data;

    assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_OUTPUT);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.img_rd    = fetch;
    assign bus.ker_rd    = fetch;
    assign bus.img_addr  = fetch ? img_addr : '0;
    assign bus.ker_addr  = fetch ? ker_addr : '0;
    assign bus.pe_a      = pe_a_w;
    assign bus.pe_b      = pe_b_w;
    assign bus.pe_en     = pe_en_q;
    assign bus.res_valid = (state_q == ST_OUTPUT);
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule
